// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single outstanding imem read, valid/ready hand-off to decode.
// Optional FETCH_BRANCH_REL_EN: target_addr is an offset from the last accepted instruction + 1.
module fetch_unit #(
    parameter int unsigned    AW       = 10,
    parameter int unsigned    DW       = 10,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_cntrl,
    input  logic [AW-1:0] target_addr,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [AW-1:0] instr_pc_q, instr_pc_d;
    logic          instr_valid_q, instr_valid_d;
    logic          redir_pend_q, redir_pend_d;
    logic [AW-1:0] redir_pc_q, redir_pc_d;
    logic [AW-1:0] eff_target;

`ifdef FETCH_BRANCH_REL_EN
    logic [AW-1:0] last_acc_pc_q, last_acc_pc_d;

    assign eff_target = last_acc_pc_q + AW'(1) + target_addr;

    always_comb begin
        last_acc_pc_d = last_acc_pc_q;
        if (instr_valid_q && instr_ready) begin
            last_acc_pc_d = instr_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_acc_pc_q <= RESET_PC;
        end else begin
            last_acc_pc_q <= last_acc_pc_d;
        end
    end
`else
    assign eff_target = target_addr;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        redir_pend_d  = redir_pend_q;
        redir_pc_d    = redir_pc_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // The read in flight always completes; a redirect only decides its fate.
                if (imem_ready) begin
                    if (fetch_cntrl) begin
                        pc_d         = eff_target;
                        redir_pend_d = 1'b0;
                    end else if (redir_pend_q) begin
                        pc_d         = redir_pc_q;
                        redir_pend_d = 1'b0;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (fetch_cntrl) begin
                    redir_pend_d = 1'b1;
                    redir_pc_d   = eff_target;
                end
            end
            S_HOLD: begin
                if (fetch_cntrl) begin
                    instr_valid_d = 1'b0;
                    pc_d          = eff_target;
                    state_d       = S_REQ;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    pc_d          = pc_q + AW'(1);
                    state_d       = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            redir_pend_q  <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            redir_pend_q  <= redir_pend_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 10-bit CPU. Holds the program counter and issues one instruction-memory read at a time.
- Buffers the returned word and hands it to decode over a valid/ready handshake.
- Consumes the branch/jump-taken bit (fetch_cntrl) and target address from the jump-control logic, and redirects the PC, discarding wrong-path words.

Parameters:
- AW, 10, PC / instruction-memory address width
- DW, 10, instruction word width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_cntrl  in  1  redirect request; 1 = branch/jump taken this cycle
- target_addr  in  AW  redirect target; sampled only when fetch_cntrl=1
- imem_req  out  1  read request to instruction memory
- imem_addr  out  AW  read address; held stable while imem_req=1
- imem_ready  in  1  memory response strobe; imem_rdata valid this cycle
- imem_rdata  in  DW  instruction word from memory
- instr  out  DW  fetched instruction to decode
- instr_pc  out  AW  address of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decode accepts instr when instr_valid=1

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=S_IDLE.
  - imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0.
  - redir_pend=0, redir_pc=0.
  - Outputs clear immediately, without waiting for a clock edge, including mid-request.
- States:
  - S_IDLE: next edge after reset release -> S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc.
    - On imem_ready=1 with no redirect pending/arriving: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, -> S_HOLD.
    - imem_ready may assert in the first S_REQ cycle (zero-wait memory). The word is then visible on instr the following cycle.
  - S_HOLD: imem_req=0, instr_valid=1.
    - On instr_ready=1: pc<=pc+1, instr_valid<=0, -> S_REQ.
    - Zero-wait throughput is one instruction per 2 cycles.
- Redirects:
  - S_HOLD + fetch_cntrl=1:
    - Held instr is discarded: instr_valid<=0, pc<=target_addr, -> S_REQ.
    - Redirect wins over a simultaneous instr_ready; pc does not increment.
  - S_REQ + fetch_cntrl=1:
    - The outstanding read is never abandoned; imem_addr stays stable.
    - If imem_ready=1 in the same cycle: response discarded, pc<=target_addr, stay S_REQ.
    - Otherwise: redir_pend<=1, redir_pc<=target_addr.
  - S_REQ + redir_pend=1 + imem_ready=1: response discarded, pc<=redir_pc, redir_pend<=0, stay S_REQ. Next cycle, imem_addr = new pc.
  - Second fetch_cntrl while redir_pend=1: redir_pc overwritten; latest target wins.
  - S_IDLE + fetch_cntrl=1: ignored.
- Arithmetic: pc+1 is modulo 2^AW, so address 1023 wraps to 0. No overflow flag.
- Output stability:
  - instr and instr_pc change only when instr_valid rises.
  - While instr_valid=1 and instr_ready=0 they are held stable.
- imem_req is a registered output, fully determined by state; imem_addr = pc.

Optional Feature:
- Macro: FETCH_BRANCH_REL_EN.
- Defined:
  - target_addr is a two's-complement AW-bit offset.
  - Effective target = last_acc_pc + 1 + target_addr, modulo 2^AW.
  - last_acc_pc is a register loaded with instr_pc on every handshake (instr_valid & instr_ready), reset to RESET_PC.
  - All redirect rules above apply to the effective target. It is computed in the cycle fetch_cntrl is sampled.
- Undefined: target_addr is an absolute address; no last_acc_pc register exists.

Test Plan:
1. Reset, zero-wait memory returning rdata=addr+0x100, instr_ready tied 1 -> instr_pc sequence 0,1,2,3 with instr 0x100..0x103; instr_valid high every other cycle; imem_req=0 during reset.
2. Memory with 3-cycle latency; assert fetch_cntrl=1, target_addr=0x050 in the second wait cycle -> imem_addr stays at old pc until imem_ready; response not presented; next imem_addr=0x050, next instr_pc=0x050.
3. S_HOLD with instr_pc=0x020, instr_ready=0; pulse fetch_cntrl with target 0x3FF and instr_ready=1 together -> instr_valid drops, 0x020 never consumed, next fetched instr_pc=0x3FF, then 0x000 (wrap).
4. instr_ready held 0 for 5 cycles -> instr/instr_pc/instr_valid stable; imem_req=0 throughout.
5. rst_n pulled low mid-request (imem_req=1, addr=0x007) between edges -> imem_req=0 and instr_valid=0 immediately; after release, first imem_addr=RESET_PC.
6. FETCH_BRANCH_REL_EN defined: accept instr_pc=0x010, then fetch_cntrl with target_addr=0x3FC (-4) -> next imem_addr=0x00D.
